// File: rtl/z16_alu_issue.sv
// z16_alu_issue: issue/write-back sequencer for the combinational Z16 ALU.
// Decodes one 16-bit instruction per handshake, reads operands from the
// internal register file, presents them to the ALU, then writes back the result.
module z16_alu_issue #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  input  logic [15:0]       i_instr,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [3:0]        o_alu_ctrl,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_done,
  output logic              o_err,
  input  logic [3:0]        i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_LAST = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] CTRL_ADD = 4'h0;

  // Sign-extend the 8-bit ADDI immediate to the datapath width.
  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [7:0] imm);
    logic signed [7:0] s;
    s = imm;
    return {{(DATA_W-8){s[7]}}, s};
  endfunction

  state_t             state_q, state_d;
  logic [15:0]        instr_q, instr_d;
  logic [DATA_W-1:0]  opa_q, opa_d;
  logic [DATA_W-1:0]  opb_q, opb_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic               bad_q, bad_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               done_q, done_d;
  logic               errp_q, errp_d;
  logic [DATA_W-1:0]  dbg_q, dbg_d;
  logic [DATA_W-1:0]  rf_q [NREG];
  logic [DATA_W-1:0]  rf_d [NREG];

  logic [3:0]         op_w, rd_w, rs_w;
  logic [7:0]         imm_w;

  assign op_w  = instr_q[3:0];
  assign rd_w  = instr_q[7:4];
  assign rs_w  = instr_q[11:8];
  assign imm_w = instr_q[15:8];

  assign o_instr_ready = (state_q == IDLE);
  assign o_alu_a       = opa_q;
  assign o_alu_b       = opb_q;
  assign o_alu_ctrl    = ctrl_q;
  assign o_done        = done_q;
  assign o_err         = errp_q;
  assign o_dbg_data    = dbg_q;

  // Next-state, decode, operand fetch, result capture and write-back.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    ctrl_d  = ctrl_q;
    bad_d   = bad_q;
    res_d   = res_q;
    done_d  = 1'b0;
    errp_d  = 1'b0;
    rf_d    = rf_q;
    dbg_d   = rf_q[i_dbg_addr];
    case (state_q)
      IDLE: begin
        if (i_instr_valid) begin
          instr_d = i_instr;
          state_d = READ;
        end
      end
      READ: begin
        if (op_w <= OP_LAST) begin
          opa_d  = rf_q[rs_w];
          opb_d  = rf_q[rd_w];
          ctrl_d = op_w;
          bad_d  = (op_w == OP_DIV) && (rf_q[rs_w] == '0);
        end else if (op_w == OP_ADDI) begin
          opa_d  = rf_q[rd_w];
          opb_d  = sext_imm(imm_w);
          ctrl_d = CTRL_ADD;
          bad_d  = 1'b0;
        end else begin
          bad_d  = 1'b1;
        end
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = i_alu_data;
        state_d = WB;
      end
      WB: begin
        if (!bad_q) rf_d[rd_w] = res_q;
        done_d  = 1'b1;
        errp_d  = bad_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and register-file flops; reset clears everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      ctrl_q  <= '0;
      bad_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      errp_q  <= 1'b0;
      dbg_q   <= '0;
      rf_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      ctrl_q  <= ctrl_d;
      bad_q   <= bad_d;
      res_q   <= res_d;
      done_q  <= done_d;
      errp_q  <= errp_d;
      dbg_q   <= dbg_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_z16_alu_issue.sv
// Testbench for z16_alu_issue: plays the combinational ALU and checks the
// sequencer against an instruction-level register model.
module tb_z16_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_a, alu_b, alu_data;
  logic [3:0]  alu_ctrl;
  logic        done, err;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mdl [16];

  always #5 clk = ~clk;

  z16_alu_issue #(.DATA_W(16), .NREG(16)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_instr_valid(instr_valid),
    .o_instr_ready(instr_ready),
    .i_instr(instr),
    .o_alu_a(alu_a),
    .o_alu_b(alu_b),
    .o_alu_ctrl(alu_ctrl),
    .i_alu_data(alu_data),
    .o_done(done),
    .o_err(err),
    .i_dbg_addr(dbg_addr),
    .o_dbg_data(dbg_data)
  );

  // Z16 ALU behaviour: result = b op a, truncated to 16 bits.
  function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (c)
      4'h0: r = b + a;
      4'h1: r = b - a;
      4'h2: r = b * a;
      4'h3: r = (a == 16'h0) ? 16'h0 : b / a;
      4'h4: r = b | a;
      4'h5: r = b & a;
      4'h6: r = b ^ a;
      4'h7: r = b << a[3:0];
      4'h8: r = b >> a[3:0];
      default: r = 16'h0;
    endcase
    return r;
  endfunction

  assign alu_data = alu_f(alu_ctrl, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference: applies one instruction to the model regfile.
  task automatic model_exec(input logic [15:0] ins, output logic e, output logic legal,
                            output logic [15:0] ea, output logic [15:0] eb, output logic [3:0] ec);
    int op, rd, rs;
    logic [15:0] imm;
    op = int'(ins[3:0]);
    rd = int'(ins[7:4]);
    rs = int'(ins[11:8]);
    imm = {{8{ins[15]}}, ins[15:8]};
    e = 1'b0; legal = 1'b1; ea = 16'h0; eb = 16'h0; ec = 4'h0;
    if (op <= 8) begin
      ea = mdl[rs]; eb = mdl[rd]; ec = ins[3:0];
      if (op == 3 && mdl[rs] == 16'h0) e = 1'b1;
      else mdl[rd] = alu_f(ins[3:0], mdl[rs], mdl[rd]);
    end else if (op == 9) begin
      ea = mdl[rd]; eb = imm; ec = 4'h0;
      mdl[rd] = mdl[rd] + imm;
    end else begin
      e = 1'b1; legal = 1'b0;
    end
  endtask

  task automatic issue(input logic [15:0] ins);
    logic e, legal;
    logic [15:0] ea, eb;
    logic [3:0] ec;
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!instr_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk("ready_before_issue", instr_ready, 1);
    model_exec(ins, e, legal, ea, eb, ec);
    instr_valid = 1'b1;
    instr = ins;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2 && legal) begin
        chk("exec_alu_a", alu_a, ea);
        chk("exec_alu_b", alu_b, eb);
        chk("exec_alu_ctrl", alu_ctrl, ec);
      end
      if (k < 4) begin
        chk("done_early", done, 0);
        chk("ready_busy", instr_ready, 0);
      end else begin
        chk("done_pulse", done, 1);
        chk("err_pulse", err, e);
      end
    end
  endtask

  task automatic chk_reg(input int r, input logic [15:0] exp);
    @(negedge clk);
    dbg_addr = 4'(r);
    @(negedge clk);
    chk($sformatf("dbg_R%0d", r), dbg_data, exp);
  endtask

  task automatic chk_all();
    for (int r = 0; r < 16; r++) chk_reg(r, mdl[r]);
  endtask

  function automatic logic [15:0] rand_instr(input int max_op);
    logic [15:0] w;
    w = 16'($urandom);
    w[3:0] = 4'($urandom_range(0, max_op));
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_cyc[$];
    int ndone;
    logic e, legal;
    logic [15:0] ea, eb, w;
    logic [3:0] ec;

    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; dbg_addr = 4'h0;
    for (int r = 0; r < 16; r++) mdl[r] = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_dbg", dbg_data, 0);
    rst = 1'b0;

    // Directed: ADDI, dependent back-to-back ops
    issue(16'h0519); chk_reg(1, 16'h0005);
    issue(16'hFD29); chk_reg(2, 16'hFFFD);
    issue(16'h0210);
    issue(16'h0112);
    chk_reg(1, 16'h0004);
    chk_reg(2, 16'hFFFD);

    // Divide by zero, then a legal divide
    issue(16'h0739);
    issue(16'h0433);
    chk_reg(3, 16'h0007);
    issue(16'h0249);
    issue(16'h0433);
    chk_reg(3, 16'h0003);
    chk_reg(4, 16'h0002);

    // Illegal op leaves the regfile alone
    issue(16'h000F);
    chk_all();

    // Valid held high with changing words: one accept every 4 cycles
    ndone = 0;
    @(negedge clk);
    for (int c = 0; c < 13; c++) begin
      w = rand_instr(9);
      instr_valid = 1'b1;
      instr = w;
      if (instr_ready) begin
        model_exec(w, e, legal, ea, eb, ec);
        acc_cyc.push_back(c);
      end
      @(negedge clk);
      if (done) ndone++;
    end
    instr_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("stream_accepts", acc_cyc.size(), 4);
    chk("stream_dones", ndone, 4);
    for (int i = 1; i < acc_cyc.size(); i++) chk("stream_gap", acc_cyc[i] - acc_cyc[i-1], 4);
    chk_all();

    // Random instructions, including illegal ops
    repeat (40) issue(rand_instr(15));
    chk_all();

    // Reset during EXEC of ADDI R5,+1
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 16'h0159;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    rst = 1'b0;
    for (int r = 0; r < 16; r++) mdl[r] = 16'h0;
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    chk_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
